// File: rtl/vga_output_module_pkg.sv
// Shared types, 640x480@60 timing constants and the 8-entry colour palette
// for the VGA scan-out path.
package vga_output_module_pkg;

  typedef struct packed {
    logic [8:0] x;
    logic [7:0] y;
  } screenXY;

  typedef logic [2:0] palcolor;

  localparam logic [9:0] H_VISIBLE    = 10'd640;
  localparam logic [9:0] H_SYNC_START = 10'd656;
  localparam logic [9:0] H_SYNC_END   = 10'd752;
  localparam logic [9:0] H_TOTAL      = 10'd800;

  localparam logic [9:0] V_VISIBLE    = 10'd480;
  localparam logic [9:0] V_SYNC_START = 10'd490;
  localparam logic [9:0] V_SYNC_END   = 10'd492;
  localparam logic [9:0] V_TOTAL      = 10'd525;

  localparam logic [11:0] PALETTE [8] = '{
    12'h000, 12'hF00, 12'h0F0, 12'h00F,
    12'hFF0, 12'h0FF, 12'hF0F, 12'hFFF
  };

endpackage

// File: rtl/vga_timing.sv
// Pixel-enable divider, horizontal/vertical counters and raw sync/visible
// decode; new_frame pulses as the counters land on (0, V_VISIBLE).
module vga_timing
  import vga_output_module_pkg::*;
#(
  parameter int PIX_DIV = 2
) (
  input  logic       Clk,
  input  logic       Reset_n,
  output logic       pix_en,
  output logic [9:0] hc,
  output logic [9:0] vc,
  output logic       visible,
  output logic       hs_raw,
  output logic       vs_raw,
  output logic       new_frame
);

  localparam int PW = (PIX_DIV > 2) ? $clog2(PIX_DIV) : 1;
  localparam logic [PW-1:0] PHASE_LAST = PW'(PIX_DIV - 1);

  logic [PW-1:0] phase;
  logic          h_last;
  logic          v_last;

  // Phase 0 is the enable slot, so the first Clk after reset advances.
  assign pix_en = (phase == '0);
  assign h_last = (hc == H_TOTAL - 10'd1);
  assign v_last = (vc == V_TOTAL - 10'd1);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      phase     <= '0;
      hc        <= '0;
      vc        <= '0;
      new_frame <= 1'b0;
    end else begin
      phase     <= (phase == PHASE_LAST) ? '0 : phase + PW'(1);
      new_frame <= pix_en && h_last && (vc == V_VISIBLE - 10'd1);
      if (pix_en) begin
        hc <= h_last ? '0 : hc + 10'd1;
        if (h_last) begin
          vc <= v_last ? '0 : vc + 10'd1;
        end
      end
    end
  end

  assign visible = (hc < H_VISIBLE) && (vc < V_VISIBLE);
  assign hs_raw  = !((hc >= H_SYNC_START) && (hc < H_SYNC_END));
  assign vs_raw  = !((vc >= V_SYNC_START) && (vc < V_SYNC_END));

endmodule

// File: rtl/vga_output_module.sv
// VGA scan-out: 320x240 framebuffer shown as 2x2 pixels at 640x480, with a
// two-stage fetch/palette pipeline keeping syncs aligned to colour.
module vga_output_module
  import vga_output_module_pkg::*;
#(
  parameter int          PIX_DIV     = 2,
  parameter logic [11:0] BLANK_COLOR = 12'h000
) (
  input  logic       Clk,
  input  logic       Reset_n,
  output screenXY    fb_coords,
  input  palcolor    fb_color,
  output logic       new_frame,
  output logic [3:0] VGA_R,
  output logic [3:0] VGA_G,
  output logic [3:0] VGA_B,
  output logic       VGA_HS,
  output logic       VGA_VS
);

  logic        pix_en;
  logic [9:0]  hc;
  logic [9:0]  vc;
  logic        visible;
  logic        hs_raw;
  logic        vs_raw;

  palcolor     s1_color;
  logic        s1_vis;
  logic        s1_hs;
  logic        s1_vs;
  logic [11:0] rgb;
  logic        unused_bits;

  vga_timing #(
    .PIX_DIV (PIX_DIV)
  ) u_timing (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .pix_en    (pix_en),
    .hc        (hc),
    .vc        (vc),
    .visible   (visible),
    .hs_raw    (hs_raw),
    .vs_raw    (vs_raw),
    .new_frame (new_frame)
  );

  // Clamp to (0,0) in blanking so the framebuffer address stays in range.
  always_comb begin
    fb_coords = '0;
    if (visible) begin
      fb_coords.x = hc[9:1];
      fb_coords.y = vc[8:1];
    end
  end

  assign unused_bits = &{1'b0, hc[0], vc[0], vc[9]};

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      s1_color <= '0;
      s1_vis   <= 1'b0;
      s1_hs    <= 1'b1;
      s1_vs    <= 1'b1;
      rgb      <= BLANK_COLOR;
      VGA_HS   <= 1'b1;
      VGA_VS   <= 1'b1;
    end else if (pix_en) begin
      s1_color <= fb_color;
      s1_vis   <= visible;
      s1_hs    <= hs_raw;
      s1_vs    <= vs_raw;
      rgb      <= s1_vis ? PALETTE[s1_color] : BLANK_COLOR;
      VGA_HS   <= s1_hs;
      VGA_VS   <= s1_vs;
    end
  end

  assign {VGA_R, VGA_G, VGA_B} = rgb;

endmodule

// File: tb/tb_vga_output_module.sv
// Scoreboard bench for vga_output_module: a counter model pushes expected
// pixels, a monitor pops them as each pixel period completes.
module tb_vga_output_module;
  import vga_output_module_pkg::*;

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b1;
  screenXY    fb_coords;
  palcolor    fb_color;
  logic       new_frame;
  logic [3:0] VGA_R, VGA_G, VGA_B;
  logic       VGA_HS, VGA_VS;

  vga_output_module #(
    .PIX_DIV     (2),
    .BLANK_COLOR (12'h000)
  ) dut (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .fb_coords (fb_coords),
    .fb_color  (fb_color),
    .new_frame (new_frame),
    .VGA_R     (VGA_R),
    .VGA_G     (VGA_G),
    .VGA_B     (VGA_B),
    .VGA_HS    (VGA_HS),
    .VGA_VS    (VGA_VS)
  );

  always #10 Clk = ~Clk;

  typedef struct {
    int rgb;
    int hs;
    int vs;
    int h;
    int v;
  } exp_t;

  int   pal [8] = '{'h000, 'hF00, 'h0F0, 'h00F, 'hFF0, 'h0FF, 'hF0F, 'hFFF};
  exp_t sb_q[$];
  event pix_ev;

  int n_tests = 0;
  int n_fail  = 0;
  int m_hc = 0, m_vc = 0, m_phase = 0;
  int nf_count = 0;
  bit hold7 = 1'b0;
  logic [9:0] jump_vc;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  function automatic exp_t expect_pixel(input int h, input int v);
    exp_t e;
    bit   vis;
    vis   = (h < 640) && (v < 480);
    e.h   = h;
    e.v   = v;
    e.rgb = vis ? (hold7 ? pal[7] : pal[(h / 2) % 8]) : 'h000;
    e.hs  = (h >= 656 && h < 752) ? 0 : 1;
    e.vs  = (v >= 490 && v < 492) ? 0 : 1;
    return e;
  endfunction

  // Framebuffer stand-in: data is x[2:0] of the address, one Clk late.
  initial begin : responder
    logic [2:0] c_prev;
    c_prev = 3'd0;
    forever begin
      @(negedge Clk);
      fb_color = hold7 ? 3'd7 : c_prev;
      c_prev   = fb_coords.x[2:0];
    end
  end

  // Counter model: pushes the pixel whose period just closed, checks coords
  // and new_frame every Clk.
  initial begin : producer
    bit pe;
    int exp_nf;
    bit vis;
    forever begin
      @(negedge Clk);
      pe = 1'b0;
      exp_nf = 0;
      if (!Reset_n) begin
        m_phase = 0;
        m_hc = 0;
        m_vc = 0;
        sb_q.delete();
      end else begin
        pe = (m_phase == 0);
        m_phase = 1 - m_phase;
        if (pe) begin
          sb_q.push_back(expect_pixel(m_hc, m_vc));
          if (m_hc == 799) begin
            m_hc = 0;
            m_vc = (m_vc == 524) ? 0 : m_vc + 1;
          end else begin
            m_hc++;
          end
          exp_nf = (m_hc == 0 && m_vc == 480) ? 1 : 0;
        end
      end
      vis = (m_hc < 640) && (m_vc < 480);
      check("new_frame", int'(new_frame), exp_nf);
      check("fb_x", int'(fb_coords.x), vis ? m_hc / 2 : 0);
      check("fb_y", int'(fb_coords.y), vis ? m_vc / 2 : 0);
      if (pe) ->pix_ev;
    end
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(pix_ev);
      if (sb_q.size() >= 2) begin
        e = sb_q.pop_front();
        check($sformatf("rgb@%0d,%0d", e.h, e.v), int'({VGA_R, VGA_G, VGA_B}), e.rgb);
        check($sformatf("hs@%0d,%0d", e.h, e.v), int'(VGA_HS), e.hs);
        check($sformatf("vs@%0d,%0d", e.h, e.v), int'(VGA_VS), e.vs);
      end
    end
  end

  initial begin : nf_counter
    forever begin
      @(negedge Clk);
      if (new_frame === 1'b1) nf_count++;
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rgb"}, int'({VGA_R, VGA_G, VGA_B}), 'h000);
    check({tag, "_hs"}, int'(VGA_HS), 1);
    check({tag, "_vs"}, int'(VGA_VS), 1);
    check({tag, "_nf"}, int'(new_frame), 0);
    check({tag, "_fbx"}, int'(fb_coords.x), 0);
    check({tag, "_fby"}, int'(fb_coords.y), 0);
  endtask

  task automatic release_reset();
    @(negedge Clk);
    #2 Reset_n = 1'b1;
  endtask

  task automatic wait_model(input int h, input int v, input int budget);
    int g;
    g = 0;
    while (!(m_hc == h && m_vc == v) && g < budget) begin
      @(negedge Clk);
      #2;
      g++;
    end
    check($sformatf("reach_%0d_%0d", h, v), int'(g < budget), 1);
  endtask

  // Skip ahead vertically: override vc across one line wrap so the counter
  // continues from target.
  task automatic jump_to_line(input int target);
    int g;
    g = 0;
    do begin
      @(negedge Clk);
      #2;
      g++;
    end while (!(m_hc == 799 && m_phase == 0) && g < 4000);
    check($sformatf("eol_before_%0d", target), int'(g < 4000), 1);
    jump_vc = 10'(target - 1);
    force dut.u_timing.vc = jump_vc;
    m_vc = target - 1;
    @(posedge Clk);
    #1;
    jump_vc = 10'(target);
    force dut.u_timing.vc = jump_vc;
    #1 release dut.u_timing.vc;
  endtask

  task automatic measure_hs();
    int g, lo, per;
    g = 0;
    while (VGA_HS !== 1'b0 && g < 4000) begin @(negedge Clk); g++; end
    check("hs_fall_seen", int'(g < 4000), 1);
    lo = 0;
    while (VGA_HS === 1'b0 && lo < 4000) begin @(negedge Clk); lo++; end
    check("hs_low_clk", lo, 192);
    per = lo;
    while (VGA_HS !== 1'b0 && per < 4000) begin @(negedge Clk); per++; end
    check("hs_period_clk", per, 1600);
  endtask

  task automatic measure_vs();
    int g, lo;
    g = 0;
    while (VGA_VS !== 1'b0 && g < 8000) begin @(negedge Clk); g++; end
    check("vs_fall_seen", int'(g < 8000), 1);
    lo = 0;
    while (VGA_VS === 1'b0 && lo < 8000) begin @(negedge Clk); lo++; end
    check("vs_low_clk", lo, 3200);
  endtask

  initial begin : main
    int nf_before;
    fb_color = 3'd0;
    #1 Reset_n = 1'b0;
    repeat (4) @(negedge Clk);
    #1 check_reset_outputs("por");

    // Normal pattern through the first rows and one line of sync timing.
    release_reset();
    measure_hs();
    wait_model(0, 4, 20000);

    // Vertical blanking: new_frame, VS width, wrap back to row 0.
    nf_before = nf_count;
    jump_to_line(480);
    repeat (10) @(negedge Clk);
    check("nf_pulses_480", nf_count - nf_before, 1);
    jump_to_line(489);
    measure_vs();
    jump_to_line(524);
    wait_model(10, 1, 8000);
    check("nf_pulses_frame", nf_count - nf_before, 1);

    // Asynchronous reset in the middle of a visible line.
    jump_to_line(200);
    wait_model(300, 200, 4000);
    @(posedge Clk);
    #3 Reset_n = 1'b0;
    #1 check_reset_outputs("mid");
    repeat (5) @(posedge Clk);
    release_reset();
    nf_before = nf_count;
    wait_model(0, 2, 8000);
    check("nf_after_mid_reset", nf_count - nf_before, 0);

    // Constant colour 7 through horizontal and vertical blanking.
    Reset_n = 1'b0;
    hold7 = 1'b1;
    repeat (3) @(negedge Clk);
    #1 check_reset_outputs("blank_rst");
    release_reset();
    wait_model(0, 2, 8000);
    jump_to_line(480);
    wait_model(10, 481, 8000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_output_module.md
VGA_OUTPUT_MODULE -- requirements
Module: vga_output_module

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clock Clk and reset Reset_n.
REQ-002 Parameter PIX_DIV, default 2: Clk cycles per VGA pixel. Only the value 2 is supported, giving 50 MHz Clk to 25 MHz pixel rate.
REQ-003 Parameter BLANK_COLOR, default 12'h000: RGB driven outside the visible area.
REQ-004 Clk  in  1  system clock (50 MHz).
REQ-005 Reset_n  in  1  asynchronous active-low reset.
REQ-006 fb_coords  out  screenXY (x 9b, y 8b)  framebuffer read coordinate (320x240 space).
REQ-007 fb_color  in  palcolor (3b)  framebuffer read data, valid 1 Clk after fb_coords.
REQ-008 new_frame  out  1  one-Clk pulse at the start of vertical blanking.
REQ-009 VGA_R, VGA_G, VGA_B  out  4 each  pixel colour.
REQ-010 VGA_HS, VGA_VS  out  1 each  syncs, active low.

Function
REQ-011 A pixel-enable pix_en SHALL assert on every second Clk and SHALL be high on the first Clk after reset release.
REQ-012 The counters SHALL advance only on pix_en. hc counts 0..799 and wraps to 0. When hc wraps, vc SHALL count 0..524 and wrap to 0.
REQ-013 Horizontal timing SHALL be: visible 0-639, front porch 640-655, sync 656-751, back porch 752-799.
REQ-014 Vertical timing SHALL be: visible 0-479, front porch 480-489, sync 490-491, back porch 492-524.
REQ-015 fb_coords SHALL be combinational from the registered counters: x = hc[9:1], y = vc[8:1]. Each framebuffer pixel is therefore shown as 2x2 VGA pixels.
REQ-016 Outside the visible area, fb_coords SHALL be clamped to (0,0) so that addresses never exceed 76799.
REQ-017 Pipeline stage 1: on the pix_en that advances the counters, fb_color (for the coordinate presented during the previous pixel period) SHALL be latched together with that period's visible flag, HS and VS.
REQ-018 Pipeline stage 2: on the next pix_en, the latched palcolor SHALL be mapped through the 8-entry PALETTE to 12-bit RGB and registered to VGA_R/G/B.
REQ-019 Total latency SHALL be 2 pixel periods (4 Clk) from a counter value to the matching RGB output.
REQ-020 VGA_HS and VGA_VS SHALL be delayed identically to RGB, so syncs and colour stay aligned.
REQ-021 When the delayed visible flag is 0, RGB SHALL equal BLANK_COLOR regardless of fb_color.
REQ-022 new_frame SHALL be high for exactly one Clk: the Clk on which the counters become hc=0, vc=480. It is never asserted in any other cycle.
REQ-023 new_frame SHALL be computed from the undelayed counters.
REQ-024 The block SHALL not depend on framebuffer state. Missed or late swaps are the framebuffer's concern.

Reset
REQ-025 While Reset_n=0, the block SHALL hold hc=0, vc=0 and pix_en phase=0, with all pipeline registers cleared.
REQ-026 While Reset_n=0, outputs SHALL be: new_frame=0, VGA_HS=1, VGA_VS=1, RGB=BLANK_COLOR, fb_coords=(0,0).
REQ-027 Reset assertion mid-line SHALL take effect immediately (asynchronously). Release SHALL restart timing at hc=0, vc=0 with no partial pulse on new_frame.

Structure
REQ-028 screenXY, palcolor, the H_/V_ timing constants and the PALETTE constant array (8 x 12-bit, index 0 = black) SHALL live in the shared structs package.
REQ-029 The counters, pix_en and raw sync/visible generation SHALL be one sub-module, vga_timing. vga_output_module instantiates it and adds the coordinate mapping, fetch pipeline and palette stage.

Verification
REQ-030 Reset release, run 1 frame: expect HS low for 192 Clk per 1600-Clk line, VS low for 2 lines per 525 lines, and a frame period of 840000 Clk.
REQ-031 Count new_frame over 3 frames: expect 3 pulses, each exactly 1 Clk wide, each on the Clk where hc=0, vc=480.
REQ-032 Drive fb_color = x[2:0] of fb_coords, delayed 1 Clk: expect RGB at VGA pixel (hc,vc) = PALETTE[(hc>>1)&7] for that pixel, 4 Clk after hc is reached, with identical output on rows 2k and 2k+1.
REQ-033 Hold fb_color=3'b111 through blanking: expect RGB=12'h000 for every pixel with hc>=640 or vc>=480, and fb_coords=(0,0) there.
REQ-034 Assert Reset_n=0 at hc=300, vc=200 for 5 Clk, then release: expect outputs immediately at reset values, timing restarting at (0,0), and the first new_frame exactly 768000 Clk after release.
